// File: rtl/regfile_8x16_pkg.sv
// Shared sizing for the 8 x 16 register file and its helpers.
package regfile_8x16_pkg;

    localparam int DATA_SIZE_DEF = 16;
    localparam int ADDR_SIZE_DEF = 3;
    localparam int NUM_REGS      = 8;

    typedef logic [ADDR_SIZE_DEF-1:0] reg_addr_t;
    typedef logic [NUM_REGS-1:0]      reg_sel_t;

    // One-hot select for a register address.
    function automatic reg_sel_t addr_to_onehot(input reg_addr_t addr);
        reg_sel_t sel;
        sel       = '0;
        sel[addr] = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/regfile_8x16_if.sv
// Register-file access bus: two read addresses, one write port, two read results.
interface regfile_8x16_if
    import regfile_8x16_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF
);

    logic [ADDR_SIZE-1:0] SR1;
    logic [ADDR_SIZE-1:0] SR2;
    logic [ADDR_SIZE-1:0] DR;
    logic [DATA_SIZE-1:0] DR_IN;
    logic                 LD;
    logic [DATA_SIZE-1:0] SR1_OUT;
    logic [DATA_SIZE-1:0] SR2_OUT;

    modport master (
        output SR1, SR2, DR, DR_IN, LD,
        input  SR1_OUT, SR2_OUT
    );

    modport slave (
        input  SR1, SR2, DR, DR_IN, LD,
        output SR1_OUT, SR2_OUT
    );

endinterface

// File: rtl/regfile_8x16_leaf.sv
// Leaf cells of the register file: storage register, write decoder, read mux.

module register_16
    import regfile_8x16_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 LD,
    input  logic [DATA_SIZE-1:0] DATA_IN,
    output logic [DATA_SIZE-1:0] DATA_OUT
);

    // Clear on reset, otherwise load when enabled and hold when not.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            DATA_OUT <= '0;
        end else if (LD) begin
            DATA_OUT <= DATA_IN;
        end
    end

endmodule

module decoder_3to8
    import regfile_8x16_pkg::*;
(
    input  reg_addr_t A,
    output reg_sel_t  Y
);

    // Exactly one output bit high for every input code.
    always_comb begin
        Y = addr_to_onehot(A);
    end

endmodule

module mux16_8to1
    import regfile_8x16_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF
) (
    input  logic [DATA_SIZE-1:0] D [NUM_REGS],
    input  reg_addr_t            SEL,
    output logic [DATA_SIZE-1:0] Y
);

    // Every select code maps to a register, so there is no default case to cover.
    always_comb begin
        Y = D[SEL];
    end

endmodule

// File: rtl/regfile_8x16.sv
// Eight-entry register file with two registered read ports and one write port.
// A cycle is either a write (LD=1) or a read (LD=0), never both, so the read
// results simply hold through writes and no write-to-read bypass is needed.
module regfile_8x16
    import regfile_8x16_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    regfile_8x16_if.slave bus
);

    reg_sel_t             dec_sel;
    reg_sel_t             reg_we;
    logic [DATA_SIZE-1:0] reg_q [NUM_REGS];
    logic [DATA_SIZE-1:0] rd1_data;
    logic [DATA_SIZE-1:0] rd2_data;
    logic                 rd_load;

    decoder_3to8 u_wr_dec (
        .A (reg_addr_t'(bus.DR)),
        .Y (dec_sel)
    );

    // Gate the one-hot decode with LD so at most one register loads per cycle.
    always_comb begin
        reg_we  = dec_sel & {NUM_REGS{bus.LD}};
        rd_load = !bus.LD;
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
        register_16 #(.DATA_SIZE(DATA_SIZE)) u_reg (
            .clk      (clk),
            .rst_n    (rst_n),
            .LD       (reg_we[k]),
            .DATA_IN  (bus.DR_IN),
            .DATA_OUT (reg_q[k])
        );
    end

    mux16_8to1 #(.DATA_SIZE(DATA_SIZE)) u_rd1_mux (
        .D   (reg_q),
        .SEL (reg_addr_t'(bus.SR1)),
        .Y   (rd1_data)
    );

    mux16_8to1 #(.DATA_SIZE(DATA_SIZE)) u_rd2_mux (
        .D   (reg_q),
        .SEL (reg_addr_t'(bus.SR2)),
        .Y   (rd2_data)
    );

    register_16 #(.DATA_SIZE(DATA_SIZE)) u_sr1_out (
        .clk      (clk),
        .rst_n    (rst_n),
        .LD       (rd_load),
        .DATA_IN  (rd1_data),
        .DATA_OUT (bus.SR1_OUT)
    );

    register_16 #(.DATA_SIZE(DATA_SIZE)) u_sr2_out (
        .clk      (clk),
        .rst_n    (rst_n),
        .LD       (rd_load),
        .DATA_IN  (rd2_data),
        .DATA_OUT (bus.SR2_OUT)
    );

endmodule

// File: tb/tb_regfile_8x16.sv
// Directed bench for regfile_8x16: each applied cycle queues its expected
// outputs; a monitor pops one entry per clock edge and compares.
module tb_regfile_8x16;

    typedef struct {
        bit          chk;
        logic [15:0] e1;
        logic [15:0] e2;
        string       name;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t exp_q[$];
    int   vectors;
    int   miscompares;
    bit   stim_done;

    regfile_8x16_if #(.DATA_SIZE(16), .ADDR_SIZE(3)) bus ();

    regfile_8x16 #(.DATA_SIZE(16), .ADDR_SIZE(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of stimulus and queue what the outputs must be after its edge.
    task automatic apply(input bit rst, input bit ld, input logic [2:0] dr,
                         input logic [15:0] din, input logic [2:0] sr1,
                         input logic [2:0] sr2, input logic [15:0] e1,
                         input logic [15:0] e2, input string name);
        exp_t e;
        @(negedge clk);
        rst_n     = ~rst;
        bus.LD    = ld;
        bus.DR    = dr;
        bus.DR_IN = din;
        bus.SR1   = sr1;
        bus.SR2   = sr2;
        e.chk  = 1'b1;
        e.e1   = e1;
        e.e2   = e2;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Monitor: one expected entry per clock edge, sampled just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    vectors++;
                    if (bus.SR1_OUT !== e.e1 || bus.SR2_OUT !== e.e2) begin
                        miscompares++;
                        $display("FAIL %s: SR1_OUT=%h SR2_OUT=%h expected %h %h",
                                 e.name, bus.SR1_OUT, bus.SR2_OUT, e.e1, e.e2);
                    end
                end
            end
        end
    end

    initial begin
        int budget;
        vectors     = 0;
        miscompares = 0;
        stim_done   = 1'b0;
        rst_n       = 1'b0;
        bus.LD      = 1'b0;
        bus.DR      = '0;
        bus.DR_IN   = '0;
        bus.SR1     = '0;
        bus.SR2     = '0;

        apply(1, 0, 0, 16'h0000, 3, 7, 16'h0000, 16'h0000, "reset_c1");
        apply(1, 0, 0, 16'h0000, 3, 7, 16'h0000, 16'h0000, "reset_c2");
        apply(0, 0, 0, 16'h0000, 3, 7, 16'h0000, 16'h0000, "reset_read_3_7");

        for (int k = 0; k < 8; k++) begin
            apply(0, 1, 3'(k), 16'(16'h1111 * k), 5, 2, 16'h0000, 16'h0000, "write_hold");
        end

        apply(0, 0, 0, 16'h0000, 5, 2, 16'h5555, 16'h2222, "read_5_2");
        apply(0, 1, 5, 16'hABCD, 5, 2, 16'h5555, 16'h2222, "hold_on_write_r5");
        apply(0, 0, 0, 16'h0000, 5, 2, 16'hABCD, 16'h2222, "read_new_r5");
        apply(0, 1, 3, 16'hFFFF, 2, 4, 16'hABCD, 16'h2222, "hold_on_write_r3");
        apply(0, 0, 0, 16'h0000, 2, 4, 16'h2222, 16'h4444, "isolation_2_4");
        apply(0, 0, 0, 16'h0000, 3, 3, 16'hFFFF, 16'hFFFF, "read_r3_both");
        apply(0, 0, 0, 16'h0000, 6, 6, 16'h6666, 16'h6666, "same_addr_6");
        apply(0, 0, 0, 16'h0000, 0, 7, 16'h0000, 16'h7777, "read_0_7");

        apply(1, 1, 1, 16'h1234, 1, 1, 16'h0000, 16'h0000, "reset_with_write");
        apply(0, 0, 0, 16'h0000, 1, 5, 16'h0000, 16'h0000, "post_reset_1_5");
        apply(0, 0, 0, 16'h0000, 7, 6, 16'h0000, 16'h0000, "post_reset_7_6");
        apply(0, 1, 1, 16'h1234, 1, 1, 16'h0000, 16'h0000, "post_reset_write");
        apply(0, 0, 0, 16'h0000, 1, 1, 16'h1234, 16'h1234, "post_reset_read_r1");

        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        @(negedge clk);
        if (exp_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        stim_done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_8x16.md
REGFILE_8X16 -- requirements
Module: regfile_8x16

Interface
REQ-001 The parameter DATA_SIZE SHALL default to 16 and set the register and data width in bits.
REQ-002 The parameter ADDR_SIZE SHALL default to 3 and set the register address width, giving 8 registers.
REQ-003 The design SHALL use one clock and a synchronous, active-low reset.
REQ-004 Port clk: input, 1 bit, the clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n: input, 1 bit, the synchronous active-low reset.
REQ-006 Port SR1: input, ADDR_SIZE bits, the read address for port 1.
REQ-007 Port SR2: input, ADDR_SIZE bits, the read address for port 2.
REQ-008 Port DR: input, ADDR_SIZE bits, the write address.
REQ-009 Port DR_IN: input, DATA_SIZE bits, the write data.
REQ-010 Port LD: input, 1 bit, the write enable; LD=1 is a write cycle and LD=0 is a read cycle.
REQ-011 Port SR1_OUT: output, DATA_SIZE bits, the registered read data for port 1.
REQ-012 Port SR2_OUT: output, DATA_SIZE bits, the registered read data for port 2.

Function
REQ-013 The design SHALL hold 8 architectural registers R0-R7, each DATA_SIZE bits wide.
REQ-014 Write: on a rising edge with rst_n=1 and LD=1, R[DR] SHALL load DR_IN, and all other registers SHALL hold their values.
REQ-015 Write decode: register k SHALL be enabled only when DR==k and LD==1.
REQ-016 There SHALL be no way to write two registers in one cycle.
REQ-017 Read: on a rising edge with rst_n=1 and LD=0:
- SR1_OUT SHALL load R[SR1];
- SR2_OUT SHALL load R[SR2].
REQ-018 Read latency SHALL be one clock, with the value appearing after the sampling edge.
REQ-019 During a write cycle (LD=1), SR1_OUT and SR2_OUT SHALL hold their previous values.
REQ-020 Because reads and writes never occur in the same cycle, no read-during-write bypass SHALL exist.
REQ-021 A value written at edge N SHALL be readable by a read cycle at edge N+1, with data valid after edge N+1.
REQ-022 SR1 and SR2 MAY be equal, and both outputs SHALL then carry the same register.
REQ-023 Addresses SHALL be fully decoded, so every 3-bit value is valid and there is no wrap or out-of-range case.
REQ-024 Outputs SHALL change only on clock edges, with no combinational path from the inputs to SR1_OUT or SR2_OUT.
REQ-025 The design SHALL contain no simulation-only display code in the synthesizable RTL.

Reset
REQ-026 On a rising edge with rst_n=0, R0-R7, SR1_OUT and SR2_OUT SHALL all become 0.
REQ-027 Reset SHALL take priority over LD, so a write or read in a reset cycle is discarded.
REQ-028 The cycle after rst_n returns to 1 SHALL operate normally.

Structure
REQ-029 A shared package SHALL hold DATA_SIZE and ADDR_SIZE defaults and the register count (8).
REQ-030 Sub-module register_16 SHALL be a clocked DATA_SIZE-bit register with ports clk, rst_n, LD, DATA_IN and DATA_OUT, which loads on LD=1 and clears on reset; 10 instances are required (8 registers and 2 output registers).
REQ-031 Leaf helper decoder_3to8 SHALL map a 3-bit input to a one-hot 8-bit output, and is used for write-enable decode.
REQ-032 Leaf helper mux16_8to1 SHALL select 1 of 8 DATA_SIZE inputs by a 3-bit SEL, with 2 instances for the read ports.
REQ-033 The output-register load SHALL equal !LD.

Verification
REQ-034 Reset: rst_n=0 for 2 cycles, then read SR1=3, SR2=7 -> SR1_OUT=0x0000 and SR2_OUT=0x0000.
REQ-035 Write and read back: write R0..R7 with 0x1111*k (k=0..7), then read SR1=5, SR2=2 -> SR1_OUT=0x5555 and SR2_OUT=0x2222 one cycle later.
REQ-036 Hold on write: after a read gives SR1_OUT=0x5555, write LD=1, DR=5, DR_IN=0xABCD -> SR1_OUT stays 0x5555 in that cycle, and the next read of SR1=5 gives 0xABCD.
REQ-037 Isolation: write DR=3 with 0xFFFF -> reading R2 and R4 returns their old values (0x2222 and 0x4444).
REQ-038 Same address: SR1=SR2=6 -> both outputs equal 0x6666.
REQ-039 Reset mid-operation: rst_n=0 on the same edge as LD=1, DR=1, DR_IN=0x1234 -> after reset, reading R1 returns 0x0000 and both outputs are 0.
